// File: rtl/recv_data_checker.sv
// ---------------------------------------------------------------------------
// recv_data_checker
//
// Receive-side checker for CAN test traffic. Each input beat is one received
// frame. Frames whose standard ID passes the acceptance filter are checked
// for length (tkeep), sequence number (byte 0) and payload pattern
// (byte i == byte0 + i, mod 256). One 3-bit result is emitted per checked
// frame. A result is also emitted when no matching frame arrives within
// TIMEOUT_CYCLE clocks.
//
// Result codes: 0 OK, 1 LEN, 2 SEQ, 3 DATA, 4 TIMEOUT.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stm_recv_data_in_*          frame stream in (tdata 64, tid 11, tkeep 8,
//                               tvalid, tready)
//   stm_result_out_*            result stream out (tdata 3, tvalid, tready)
//   ok_count                    number of OK results, saturating
//   err_count                   number of non-OK results, saturating
//   err                         last accepted result was non-OK
// ---------------------------------------------------------------------------
module recv_data_checker #(
    parameter logic [10:0] ACCEPT_ID     = 11'h123,
    parameter logic [10:0] ACCEPT_MASK   = 11'h7FF,
    parameter int          EXP_BYTES     = 8,
    parameter int          TIMEOUT_CYCLE = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] stm_recv_data_in_tdata,
    input  logic [10:0] stm_recv_data_in_tid,
    input  logic [7:0]  stm_recv_data_in_tkeep,
    input  logic        stm_recv_data_in_tvalid,
    output logic        stm_recv_data_in_tready,
    output logic [2:0]  stm_result_out_tdata,
    output logic        stm_result_out_tvalid,
    input  logic        stm_result_out_tready,
    output logic [15:0] ok_count,
    output logic [15:0] err_count,
    output logic        err
);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    localparam logic [2:0] RES_OK      = 3'd0;
    localparam logic [2:0] RES_LEN     = 3'd1;
    localparam logic [2:0] RES_SEQ     = 3'd2;
    localparam logic [2:0] RES_DATA    = 3'd3;
    localparam logic [2:0] RES_TIMEOUT = 3'd4;

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLE);
    localparam logic [TIMER_W-1:0] TIMER_TERM = TIMER_W'(TIMEOUT_CYCLE - 1);

    // An exact mask comparison rejects both short and non-contiguous keeps.
    localparam logic [8:0] KEEP_FULL_W = (9'd1 << EXP_BYTES) - 9'd1;
    localparam logic [7:0] KEEP_FULL   = KEEP_FULL_W[7:0];

    // Priority LEN > SEQ > DATA > OK.
    function automatic logic [2:0] frame_code(input logic [63:0] data,
                                              input logic [7:0]  keep,
                                              input logic        synced,
                                              input logic [7:0]  exp_seq);
        logic       data_bad;
        logic [2:0] code;
        data_bad = 1'b0;
        for (int i = 1; i < EXP_BYTES; i++) begin
            if (data[8*i +: 8] != data[7:0] + 8'(i))
                data_bad = 1'b1;
        end
        if (keep != KEEP_FULL)
            code = RES_LEN;
        else if (synced && (data[7:0] != exp_seq))
            code = RES_SEQ;
        else if (data_bad)
            code = RES_DATA;
        else
            code = RES_OK;
        return code;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]         state;
    logic               rdy_en;
    logic [TIMER_W-1:0] timer;
    logic               seq_synced;
    logic [7:0]         expected_seq;
    logic [63:0]        data_p0;
    logic [7:0]         keep_p0;
    logic [2:0]         code_p1;
    logic               vld_p0;
    logic               vld_p1;
    logic               in_xfer;
    logic               id_match;
    logic               match_xfer;
    logic               timeout_fire;
    logic               res_xfer;

    // rdy_en keeps tready low while reset is asserted.
    assign stm_recv_data_in_tready = rdy_en && (state == ST_WAIT);
    assign vld_p0       = (state == ST_CHECK);
    assign vld_p1       = (state == ST_REPORT);
    assign in_xfer      = stm_recv_data_in_tvalid && stm_recv_data_in_tready;
    assign id_match     = (((stm_recv_data_in_tid ^ ACCEPT_ID) & ACCEPT_MASK) == 11'd0);
    assign match_xfer   = in_xfer && id_match;
    // A matching frame arriving on the expiry cycle takes precedence.
    assign timeout_fire = (state == ST_WAIT) && (timer == TIMER_TERM) && !match_xfer;
    assign res_xfer     = vld_p1 && stm_result_out_tready;

    assign stm_result_out_tvalid = vld_p1;
    assign stm_result_out_tdata  = code_p1;

    // ---- stage p0: capture matching frame ----
    always_ff @(posedge clk) begin
        if (match_xfer) begin
            data_p0 <= stm_recv_data_in_tdata;
            keep_p0 <= stm_recv_data_in_tkeep;
        end
    end

    // ---- stage p1: check, report and bookkeeping ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_WAIT;
            rdy_en       <= 1'b0;
            timer        <= '0;
            seq_synced   <= 1'b0;
            expected_seq <= 8'd0;
            code_p1      <= RES_OK;
            ok_count     <= 16'd0;
            err_count    <= 16'd0;
            err          <= 1'b0;
        end else begin
            rdy_en <= 1'b1;

            // The timer runs in every state and parks at its terminal value
            // so an expiry during CHECK/REPORT is served on return to WAIT.
            if (match_xfer || timeout_fire)
                timer <= '0;
            else if (timer != TIMER_TERM)
                timer <= timer + TIMER_W'(1);

            case (state)
                ST_WAIT: begin
                    if (match_xfer) begin
                        state <= ST_CHECK;
                    end else if (timeout_fire) begin
                        code_p1 <= RES_TIMEOUT;
                        state   <= ST_REPORT;
                    end
                end
                ST_CHECK: begin
                    if (vld_p0) begin
                        code_p1 <= frame_code(data_p0, keep_p0, seq_synced, expected_seq);
                        // A length error leaves sequence tracking untouched;
                        // anything else resynchronises on this frame's byte 0.
                        if (keep_p0 == KEEP_FULL) begin
                            expected_seq <= data_p0[7:0] + 8'd1;
                            seq_synced   <= 1'b1;
                        end
                    end
                    state <= ST_REPORT;
                end
                ST_REPORT: begin
                    if (res_xfer) begin
                        err <= (code_p1 != RES_OK);
                        if (code_p1 == RES_OK)
                            ok_count <= sat_inc16(ok_count);
                        else
                            err_count <= sat_inc16(err_count);
                        state <= ST_WAIT;
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_recv_data_checker.sv
// ---------------------------------------------------------------------------
// tb_recv_data_checker
//
// Two checker instances share one stimulus bus: dut_a (exact ID filter,
// long timeout) carries the frame-checking traffic, dut_b (filter disabled,
// 20-cycle timeout) carries the timeout scenarios. sel routes the handshakes.
// ---------------------------------------------------------------------------
module tb_recv_data_checker;

    localparam int EXPB = 8;
    localparam int A_TO = 1000;
    localparam int B_TO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [63:0] tdata;
    logic [10:0] tid;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        rtready;

    logic        a_tvalid, b_tvalid, a_rtready, b_rtready;
    logic        a_tready, b_tready, a_rvld, b_rvld, a_err, b_err;
    logic [2:0]  a_rdata, b_rdata;
    logic [15:0] a_ok, b_ok, a_ec, b_ec;

    logic        in_tready, r_tvalid, err_o;
    logic [2:0]  r_tdata;
    logic [15:0] ok_cnt_o, err_cnt_o;

    always #5 clk = ~clk;

    assign a_tvalid  = tvalid & ~sel;
    assign b_tvalid  = tvalid & sel;
    assign a_rtready = rtready & ~sel;
    assign b_rtready = rtready & sel;

    assign in_tready = sel ? b_tready : a_tready;
    assign r_tvalid  = sel ? b_rvld   : a_rvld;
    assign r_tdata   = sel ? b_rdata  : a_rdata;
    assign ok_cnt_o  = sel ? b_ok     : a_ok;
    assign err_cnt_o = sel ? b_ec     : a_ec;
    assign err_o     = sel ? b_err    : a_err;

    recv_data_checker #(
        .ACCEPT_ID(11'h123), .ACCEPT_MASK(11'h7FF), .EXP_BYTES(EXPB), .TIMEOUT_CYCLE(A_TO)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .stm_recv_data_in_tdata(tdata), .stm_recv_data_in_tid(tid),
        .stm_recv_data_in_tkeep(tkeep), .stm_recv_data_in_tvalid(a_tvalid),
        .stm_recv_data_in_tready(a_tready),
        .stm_result_out_tdata(a_rdata), .stm_result_out_tvalid(a_rvld),
        .stm_result_out_tready(a_rtready),
        .ok_count(a_ok), .err_count(a_ec), .err(a_err)
    );

    recv_data_checker #(
        .ACCEPT_ID(11'h123), .ACCEPT_MASK(11'h000), .EXP_BYTES(EXPB), .TIMEOUT_CYCLE(B_TO)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .stm_recv_data_in_tdata(tdata), .stm_recv_data_in_tid(tid),
        .stm_recv_data_in_tkeep(tkeep), .stm_recv_data_in_tvalid(b_tvalid),
        .stm_recv_data_in_tready(b_tready),
        .stm_result_out_tdata(b_rdata), .stm_result_out_tvalid(b_rvld),
        .stm_result_out_tready(b_rtready),
        .ok_count(b_ok), .err_count(b_ec), .err(b_err)
    );

    // Reference model state
    bit m_synced;
    int m_exp;
    int m_ok;
    int m_ec;
    bit m_err;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_synced = 1'b0;
        m_exp    = 0;
        m_ok     = 0;
        m_ec     = 0;
        m_err    = 1'b0;
    endtask

    function automatic logic [63:0] mk_pat(input int b0);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'((b0 + i) % 256);
        return r;
    endfunction

    function automatic logic [2:0] ref_code(input logic [63:0] d, input logic [7:0] k);
        int b0;
        b0 = int'(d[7:0]);
        if (int'(k) != (1 << EXPB) - 1) return 3'd1;
        if (m_synced && b0 != m_exp) return 3'd2;
        for (int i = 1; i < EXPB; i++)
            if (int'(d[8*i +: 8]) != (b0 + i) % 256) return 3'd3;
        return 3'd0;
    endfunction

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic put_frame(input logic [10:0] id, input logic [63:0] d, input logic [7:0] k);
        int guard;
        guard = 0;
        while (in_tready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("in_ready_wait", 32'(in_tready), 32'd1);
        tid    = id;
        tdata  = d;
        tkeep  = k;
        tvalid = 1'b1;
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic do_frame(input logic [10:0] id, input logic [63:0] d,
                            input logic [7:0] k, input int hold);
        logic [10:0] mask;
        logic [2:0]  code;
        mask    = sel ? 11'h000 : 11'h7FF;
        rtready = (hold == 0);
        put_frame(id, d, k);
        if (((id ^ 11'h123) & mask) != 11'd0) begin
            chk("drop_rdy", 32'(in_tready), 32'd1);
            chk("drop_vld", 32'(r_tvalid), 32'd0);
            rtready = 1'b1;
            return;
        end
        code = ref_code(d, k);
        if (code != 3'd1) begin
            m_exp    = (int'(d[7:0]) + 1) % 256;
            m_synced = 1'b1;
        end
        chk("lat_cycle1", 32'(r_tvalid), 32'd0);
        @(negedge clk);
        chk("res_vld", 32'(r_tvalid), 32'd1);
        chk("res_code", 32'(r_tdata), 32'(code));
        chk("in_busy", 32'(in_tready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_vld", 32'(r_tvalid), 32'd1);
            chk("hold_code", 32'(r_tdata), 32'(code));
            chk("hold_inrdy", 32'(in_tready), 32'd0);
        end
        rtready = 1'b1;
        @(negedge clk);
        m_err = (code != 3'd0);
        if (code == 3'd0) m_ok = (m_ok < 65535) ? m_ok + 1 : 65535;
        else              m_ec = (m_ec < 65535) ? m_ec + 1 : 65535;
        chk("err", 32'(err_o), 32'(m_err));
        chk("ok_count", 32'(ok_cnt_o), 32'(m_ok));
        chk("err_count", 32'(err_cnt_o), 32'(m_ec));
        chk("res_done", 32'(r_tvalid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  k;
        logic [10:0] id;
        int          b0;
        int          j;
        int          next_at;

        sel     = 1'b0;
        tvalid  = 1'b0;
        rtready = 1'b1;
        tdata   = '0;
        tid     = '0;
        tkeep   = '0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_tready", 32'(in_tready), 32'd0);
        chk("rst_r_tvalid", 32'(r_tvalid), 32'd0);
        chk("rst_r_tdata", 32'(r_tdata), 32'd0);
        chk("rst_ok", 32'(ok_cnt_o), 32'd0);
        chk("rst_ec", 32'(err_cnt_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        // Basic OK frames, sequence error and resync
        do_frame(11'h123, mk_pat(8'h05), 8'hFF, 0);
        do_frame(11'h123, mk_pat(8'h06), 8'hFF, 0);
        do_frame(11'h123, mk_pat(8'h10), 8'hFF, 0);
        do_frame(11'h123, mk_pat(8'h14), 8'hFF, 0);
        do_frame(11'h123, mk_pat(8'h15), 8'hFF, 0);
        // Length errors leave sequence state alone
        do_frame(11'h123, mk_pat(8'h16), 8'h7F, 0);
        do_frame(11'h123, mk_pat(8'h16), 8'hFD, 0);
        do_frame(11'h123, mk_pat(8'h16), 8'hFF, 0);
        // Wrap-around of sequence and pattern
        do_frame(11'h123, mk_pat(8'hFB), 8'hFF, 0);
        do_frame(11'h123, mk_pat(8'hFC), 8'hFF, 0);
        do_frame(11'h123, mk_pat(8'hFF), 8'hFF, 0);
        do_frame(11'h123, mk_pat(8'h00), 8'hFF, 0);
        // Payload error, and LEN taking priority over it
        d = mk_pat(8'h01);
        d[31:24] = 8'hAA;
        do_frame(11'h123, d, 8'hFF, 0);
        d = mk_pat(8'h02);
        d[15:8] = 8'h00;
        do_frame(11'h123, d, 8'h0F, 0);
        // Filtered ID is consumed without a result
        do_frame(11'h124, mk_pat(8'h02), 8'hFF, 0);
        do_frame(11'h123, mk_pat(8'h02), 8'hFF, 0);
        // Result back-pressure
        do_frame(11'h123, mk_pat(m_exp), 8'hFF, 50);

        // Counter saturation
        force dut_a.ok_count = 16'hFFFE;
        #1 release dut_a.ok_count;
        m_ok = 65534;
        @(negedge clk);
        do_frame(11'h123, mk_pat(m_exp), 8'hFF, 0);
        do_frame(11'h123, mk_pat(m_exp), 8'hFF, 0);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            b0 = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 255)) : m_exp;
            d  = mk_pat(b0);
            if ($urandom_range(0, 7) == 0) begin
                j = int'($urandom_range(1, 7));
                d[8*j +: 8] = d[8*j +: 8] ^ 8'(1 << $urandom_range(0, 7));
            end
            k  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
            id = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'h123;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_frame(id, d, k, 0);
        end

        // Reset while a result is pending
        rtready = 1'b0;
        put_frame(11'h123, mk_pat(m_exp), 8'h0F);
        @(negedge clk);
        chk("pre_rst_vld", 32'(r_tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_tready", 32'(in_tready), 32'd0);
        chk("mid_rst_r_tvalid", 32'(r_tvalid), 32'd0);
        chk("mid_rst_r_tdata", 32'(r_tdata), 32'd0);
        chk("mid_rst_ok", 32'(ok_cnt_o), 32'd0);
        chk("mid_rst_ec", 32'(err_cnt_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        rtready = 1'b1;
        model_reset();
        @(negedge clk);
        do_frame(11'h123, mk_pat(8'h77), 8'hFF, 0);
        do_frame(11'h123, mk_pat(8'h78), 8'hFF, 0);

        // ---------------- dut_b: mask 0, 20-cycle timeout ----------------
        sel   = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("b_rst_vld", 32'(r_tvalid), 32'd0);
        chk("b_rst_code", 32'(r_tdata), 32'd0);
        chk("b_rst_ec", 32'(err_cnt_o), 32'd0);
        rst_n = 1'b1;
        model_reset();
        // Frame presented on the expiry cycle wins over the timeout
        repeat (B_TO - 1) @(negedge clk);
        do_frame(11'h124, mk_pat(8'h40), 8'hFF, 0);
        repeat (B_TO - 3) @(negedge clk);
        chk("b_no_early_to", 32'(r_tvalid), 32'd0);
        @(negedge clk);
        chk("b_to_vld", 32'(r_tvalid), 32'd1);
        chk("b_to_code", 32'(r_tdata), 32'd4);
        @(negedge clk);
        m_ec++;
        chk("b_to_err", 32'(err_o), 32'd1);
        chk("b_to_ec", 32'(err_cnt_o), 32'(m_ec));

        // Periodic timeouts with no input
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        next_at = B_TO;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (r_tvalid) begin
                chk("to_at_cycle", 32'(i), 32'(next_at));
                chk("to_code", 32'(r_tdata), 32'd4);
                next_at = next_at + B_TO;
            end
        end
        chk("to_count", 32'(err_cnt_o), 32'd3);
        chk("to_err", 32'(err_o), 32'd1);
        m_ec  = 3;
        m_err = 1'b1;

        // Expiry while held in REPORT is served on the first WAIT cycle
        do_frame(11'h555, mk_pat(8'h20), 8'hFF, 25);
        @(negedge clk);
        chk("to_after_hold_vld", 32'(r_tvalid), 32'd1);
        chk("to_after_hold_code", 32'(r_tdata), 32'd4);
        @(negedge clk);
        m_ec++;
        chk("to_after_hold_ec", 32'(err_cnt_o), 32'(m_ec));
        chk("to_after_hold_err", 32'(err_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
